// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit: EX forward select, ID write-through bypass,
// load-use stall FSM with configurable bubble count and saturating counter.
module hazard_forward_unit #(
    parameter int ADDR_W    = 5,
    parameter int NUM_SRC   = 2,
    parameter int STALL_CYC = 1,
    parameter int CNT_W     = 32
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_SRC*ADDR_W-1:0] ID_Src,
    input  logic [NUM_SRC-1:0]        ID_SrcUsed,
    input  logic [NUM_SRC*ADDR_W-1:0] EX_Src,
    input  logic                      EX_RegWrite,
    input  logic                      EX_MemRead,
    input  logic [ADDR_W-1:0]         EX_WriteReg,
    input  logic                      MEM_RegWrite,
    input  logic                      MEM_MemRead,
    input  logic [ADDR_W-1:0]         MEM_WriteReg,
    input  logic                      WB_RegWrite,
    input  logic [ADDR_W-1:0]         WB_WriteReg,
    input  logic                      Flush,
    output logic [2*NUM_SRC-1:0]      Fwd,
    output logic [NUM_SRC-1:0]        IDBypass,
    output logic                      Stall,
    output logic                      PCWrite,
    output logic                      IFIDWrite,
    output logic                      IDEXBubble,
    output logic [CNT_W-1:0]          StallCount
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [3:0] BUB_INIT =
        4'((STALL_CYC > 1) ? (STALL_CYC - 2) : 0);

    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_bub;
    logic [3:0]        w_bub_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_hazard;
    logic              w_stall;
    logic [2*NUM_SRC-1:0] w_fwd;
    logic [NUM_SRC-1:0]   w_byp;

    wire w_mem_ok = MEM_RegWrite & ~MEM_MemRead & (MEM_WriteReg != '0);
    wire w_wb_ok  = WB_RegWrite & (WB_WriteReg != '0);
    wire w_ld_ok  = EX_RegWrite & EX_MemRead & (EX_WriteReg != '0);

    always_comb begin
        w_fwd    = '0;
        w_byp    = '0;
        w_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_mem_ok && MEM_WriteReg == EX_Src[i*ADDR_W +: ADDR_W])
                w_fwd[2*i +: 2] = 2'd1;
            else if (w_wb_ok && WB_WriteReg == EX_Src[i*ADDR_W +: ADDR_W])
                w_fwd[2*i +: 2] = 2'd2;
            if (w_wb_ok && ID_SrcUsed[i] &&
                WB_WriteReg == ID_Src[i*ADDR_W +: ADDR_W])
                w_byp[i] = 1'b1;
            if (w_ld_ok && ID_SrcUsed[i] &&
                EX_WriteReg == ID_Src[i*ADDR_W +: ADDR_W])
                w_hazard = 1'b1;
        end
    end

    // STALL ignores the hazard term: the load has already moved past EX
    always_comb begin
        w_stall    = 1'b0;
        w_state_nx = r_state;
        w_bub_nx   = r_bub;
        unique case (r_state)
            RUN: begin
                w_stall = w_hazard & ~Flush;
                if (w_stall && STALL_CYC > 1) begin
                    w_state_nx = STALL;
                    w_bub_nx   = BUB_INIT;
                end
            end
            STALL: begin
                w_stall = ~Flush;
                if (Flush || r_bub == 4'd0)
                    w_state_nx = RUN;
                else
                    w_bub_nx = r_bub - 4'd1;
            end
            default: w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= RUN;
            r_bub   <= 4'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_bub   <= w_bub_nx;
            if (w_stall && r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Fwd        = Rst ? w_fwd : '0;
    assign IDBypass   = Rst ? w_byp : '0;
    assign Stall      = Rst & w_stall;
    assign PCWrite    = ~Stall;
    assign IFIDWrite  = ~Stall;
    assign IDEXBubble = Rst & (w_stall | Flush);
    assign StallCount = r_cnt;

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised successor to the EX-stage forwarding unit, covering NUM_SRC source operands. It combines EX-stage forward selection with an ID-stage regfile write-through bypass and a load-use stall FSM. The FSM supports a configurable bubble count and a branch-flush override, and the block keeps a saturating stall-cycle counter. It sits between the ID/EX pipeline registers and the PC/IF-ID write enables of the 5-stage datapath.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction (rs, rt, ...)
STALL_CYC, 1, bubbles inserted per load-use hazard (1..15)
CNT_W, 32, width of stall-cycle counter

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
ID_Src  in  NUM_SRC*ADDR_W  ID-stage source register numbers; operand i occupies bits [i*ADDR_W +: ADDR_W]
ID_SrcUsed  in  NUM_SRC  per-operand "register actually read" flag
EX_Src  in  NUM_SRC*ADDR_W  EX-stage source register numbers, same packing
EX_RegWrite  in  1  EX instruction writes a register
EX_MemRead  in  1  EX instruction is a load
EX_WriteReg  in  ADDR_W  EX destination
MEM_RegWrite  in  1  MEM instruction writes a register
MEM_MemRead  in  1  MEM instruction is a load
MEM_WriteReg  in  ADDR_W  MEM destination
WB_RegWrite  in  1  WB instruction writes a register
WB_WriteReg  in  ADDR_W  WB destination
Flush  in  1  taken branch/jump; cancels ID instruction
Fwd  out  2*NUM_SRC  per-operand EX mux select: 0 regfile, 1 EX/MEM, 2 MEM/WB
IDBypass  out  NUM_SRC  per-operand: ID read takes WB write data
Stall  out  1  hold ID instruction this cycle
PCWrite  out  1  = ~Stall
IFIDWrite  out  1  = ~Stall
IDEXBubble  out  1  zero ID/EX control signals = Stall | Flush
StallCount  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (Rst low, async): state RUN, bubble counter 0, StallCount 0. While Rst is low, all outputs are 0, except PCWrite and IFIDWrite, which are 1.
- Register 0 never matches, for forwarding, bypass, or hazard.
- Fwd[i], combinational: 1 if MEM_RegWrite & ~MEM_MemRead & MEM_WriteReg==EX_Src[i]. Else 2 if WB_RegWrite & WB_WriteReg==EX_Src[i]. Else 0. MEM has priority over WB.
- Loads are never forwarded from EX/MEM. Load data comes only from MEM/WB.
- IDBypass[i]: WB_RegWrite & WB_WriteReg==ID_Src[i] & ID_SrcUsed[i].
- Hazard: EX_RegWrite & EX_MemRead & EX_WriteReg==ID_Src[i] & ID_SrcUsed[i], for any operand i.
- FSM states are RUN and STALL. A 4-bit counter `bub` is used in STALL.
  - RUN: Stall = hazard & ~Flush. If Stall and STALL_CYC>1, go to STALL with bub=STALL_CYC-2. Otherwise stay in RUN.
  - STALL: Stall = ~Flush. If Flush, go to RUN. Else if bub==0, go to RUN. Else bub decrements.
  - STALL ignores new hazard evaluation, because the load has already left EX.
- Flush has priority over every stall condition in the same cycle: Stall=0 and IDEXBubble=1.
- Total stall length per hazard is exactly STALL_CYC cycles. Re-detection in RUN after the bubbles is a new hazard only if a new load sits in EX.
- StallCount increments on every rising edge where Stall=1. It holds at all-ones (no wrap).
- Reset asserted mid-stall: immediate return to RUN and Stall=0 without waiting for a clock. After release, the first edge behaves as a normal RUN cycle.
- All combinational outputs are glitch-tolerant: they are sampled only at the clock edge by downstream registers.

Test Plan:
1. EX_Src={rt=9,rs=8}; MEM writes r8 (ALU) and WB writes r8 -> Fwd[1:0]=1. WB writes r9 -> Fwd[3:2]=2. MEM writes r0 -> Fwd=0.
2. Load r5 in EX; ID reads r5 with SrcUsed=1; STALL_CYC=1 -> Stall=1 for exactly one cycle, PCWrite=0, IDEXBubble=1, StallCount 0->1. Repeat with SrcUsed=0 -> no stall.
3. STALL_CYC=3; load-use on r7 -> Stall high for 3 consecutive cycles, then 0, and StallCount=3. Same case with MEM_MemRead=1 and MEM_WriteReg=7 -> Fwd does not select 1.
4. STALL_CYC=3; Flush asserted in the second stall cycle -> Stall=0 that cycle, IDEXBubble=1, state RUN next cycle. StallCount=1.
5. Rst driven low mid-stall -> Stall=0 and StallCount=0 immediately, without a clock edge. After release, load-use stall behaves normally.
6. CNT_W=4; force 20 stall cycles -> StallCount saturates at 15. WB writes r3 while ID reads r3 -> IDBypass bit set.
